// File: rtl/pc_target_table.sv
// Programmable branch-target table: DEPTH absolute/PC-relative entries,
// registered target with taken/miss status one cycle after a lookup.
module pc_target_table #(
    parameter int D     = 10,
    parameter int A     = 8,
    parameter int DEPTH = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         branch,
    input  logic [A-1:0] addr,
    input  logic [D-1:0] pc,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic [D-1:0] wr_data,
    input  logic         wr_rel,
    input  logic         wr_inval,
    input  logic         clr,
    output logic [D-1:0] target,
    output logic         taken,
    output logic         miss
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [A:0] DEPTH_W = DEPTH[A:0];

    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [DEPTH-1:0]        rel_q, rel_d;
    logic [DEPTH-1:0][D-1:0] data_q, data_d;

    logic [D-1:0] target_q, target_d;
    logic         taken_q, taken_d;
    logic         miss_q, miss_d;

    logic          wr_ok, rd_ok, hit;
    logic [IW-1:0] widx, ridx;

    assign wr_ok = ({1'b0, wr_addr} < DEPTH_W);
    assign rd_ok = ({1'b0, addr} < DEPTH_W);
    assign widx  = wr_addr[IW-1:0];
    assign ridx  = addr[IW-1:0];

    // Post-update state; the lookup reads it so same-cycle writes bypass.
    always_comb begin
        valid_d = clr ? '0 : valid_q;
        rel_d   = rel_q;
        data_d  = data_q;
        if (wr_en && wr_ok) begin
            if (wr_inval) begin
                valid_d[widx] = 1'b0;
            end else begin
                valid_d[widx] = 1'b1;
                rel_d[widx]   = wr_rel;
                data_d[widx]  = wr_data;
            end
        end
    end

    always_comb begin
        target_d = '0;
        taken_d  = 1'b0;
        miss_d   = 1'b0;
        hit      = rd_ok && valid_d[ridx];
        if (branch) begin
            if (hit) begin
                taken_d  = 1'b1;
                target_d = rel_d[ridx] ? pc + data_d[ridx] : data_d[ridx];
            end else begin
                miss_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            valid_q  <= '0;
            target_q <= '0;
            taken_q  <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            target_q <= target_d;
            taken_q  <= taken_d;
            miss_q   <= miss_d;
        end
    end

    // Payload is meaningless while invalid, so it carries no reset.
    always_ff @(posedge Clk) begin
        rel_q  <= rel_d;
        data_q <= data_d;
    end

    assign target = target_q;
    assign taken  = taken_q;
    assign miss   = miss_q;

endmodule

// File: tb/tb_pc_target_table.sv
// Randomized + directed bench for pc_target_table against a table model.
module tb_pc_target_table;

    localparam int D     = 10;
    localparam int A     = 8;
    localparam int DEPTH = 16;
    localparam int MASK  = (1 << D) - 1;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         branch;
    logic [A-1:0] addr;
    logic [D-1:0] pc;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [D-1:0] wr_data;
    logic         wr_rel;
    logic         wr_inval;
    logic         clr;
    logic [D-1:0] target;
    logic         taken;
    logic         miss;

    int total = 0;
    int bad   = 0;

    bit mv[DEPTH];
    bit mr[DEPTH];
    int md[DEPTH];
    int e_t;
    bit e_tk;
    bit e_ms;

    pc_target_table #(.D(D), .A(A), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .branch(branch), .addr(addr), .pc(pc),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_rel(wr_rel), .wr_inval(wr_inval), .clr(clr),
        .target(target), .taken(taken), .miss(miss)
    );

    always #5 Clk = ~Clk;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
        e_t = 0; e_tk = 1'b0; e_ms = 1'b0;
    endtask

    task automatic cmp(input string nm, input int t, input bit tk, input bit ms);
        total++;
        if (int'(target) != t || taken !== tk || miss !== ms) begin
            bad++;
            $display("FAIL %s: got target=%0d taken=%b miss=%b, want target=%0d taken=%b miss=%b",
                     nm, target, taken, miss, t, tk, ms);
        end
    endtask

    // One cycle: apply inputs, advance the model, check the registered result.
    task automatic drive(input bit br, input int ad, input int p,
                         input bit we, input int wa, input int wd,
                         input bit wrel, input bit winv, input bit c);
        branch = br; addr = A'(ad); pc = D'(p);
        wr_en = we; wr_addr = A'(wa); wr_data = D'(wd);
        wr_rel = wrel; wr_inval = winv; clr = c;
        if (c) for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
        if (we && wa < DEPTH) begin
            if (winv) mv[wa] = 1'b0;
            else begin
                mv[wa] = 1'b1; mr[wa] = wrel; md[wa] = wd & MASK;
            end
        end
        e_t = 0; e_tk = 1'b0; e_ms = 1'b0;
        if (br) begin
            if (ad < DEPTH && mv[ad]) begin
                e_tk = 1'b1;
                e_t  = mr[ad] ? ((p + md[ad]) & MASK) : md[ad];
            end else begin
                e_ms = 1'b1;
            end
        end
        @(posedge Clk);
        #1;
        cmp("model", e_t, e_tk, e_ms);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int wa, input int wd, input bit wrel);
        drive(0, 0, 0, 1, wa, wd, wrel, 0, 0);
    endtask

    task automatic look(input int ad, input int p);
        drive(1, ad, p, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        Reset = 1'b1;
        branch = 0; addr = '0; pc = '0; wr_en = 0; wr_addr = '0;
        wr_data = '0; wr_rel = 0; wr_inval = 0; clr = 0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        cmp("reset_state", 0, 0, 0);
        Reset = 1'b0;

        look(0, 0);                cmp("first_miss", 0, 0, 1);
        wr(1, 20, 0);              cmp("branch0_zero", 0, 0, 0);
        look(1, 0);                cmp("abs_hit", 20, 1, 0);
        idle();                    cmp("branch0", 0, 0, 0);

        wr(2, 'h3FE, 1);
        look(2, 5);                cmp("rel_wrap", 3, 1, 0);
        look(2, 0);                cmp("rel_pc0", 'h3FE, 1, 0);
        wr(3, 4, 1);
        look(3, 'h3FE);            cmp("rel_wrap_up", 2, 1, 0);

        drive(1, 4, 0, 1, 4, 99, 0, 0, 0);  cmp("bypass_wr", 99, 1, 0);
        drive(1, 1, 0, 1, 1, 0, 0, 1, 0);   cmp("bypass_inval", 0, 0, 1);

        wr(0, 11, 0);
        wr(1, 21, 0);
        drive(1, 0, 0, 1, 3, 7, 0, 0, 1);   cmp("clr_lookup", 0, 0, 1);
        look(1, 0);                cmp("clr_gone", 0, 0, 1);
        look(3, 0);                cmp("clr_kept", 7, 1, 0);
        drive(1, 3, 0, 0, 0, 0, 0, 0, 1);   cmp("clr_same_cycle", 0, 0, 1);

        wr(16, 55, 0);
        look(16, 0);               cmp("oob_miss", 0, 0, 1);
        wr(15, 100, 0);
        wr(1, 33, 0);
        look(15, 0);               cmp("last_entry", 100, 1, 0);
        look(1, 0);                cmp("b2b_1", 33, 1, 0);
        look(15, 0);               cmp("b2b_15", 100, 1, 0);
        look(16, 0);               cmp("b2b_16", 0, 0, 1);

        look(15, 0);               cmp("pre_async", 100, 1, 0);
        branch = 1'b1; addr = 8'd15;
        #2 Reset = 1'b1;
        #1 cmp("async_reset", 0, 0, 0);
        model_reset();
        @(posedge Clk);
        #1 Reset = 1'b0;
        look(15, 0);               cmp("after_reset_miss", 0, 0, 1);

        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 19),
                  $urandom_range(0, MASK),
                  $urandom_range(0, 1), $urandom_range(0, 19),
                  $urandom_range(0, MASK), $urandom_range(0, 1),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 32) == 0);
            if (taken && miss) begin
                total++;
                bad++;
                $display("FAIL exclusive: taken=%b miss=%b, want not both", taken, miss);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
